// File: rtl/pixel_writer.sv
// pixel_writer: tail of the drawer pixel stream. Buffers incoming pixels in a
// small FIFO, drops off-screen pixels, turns the rest into linear frame-buffer
// writes that may be stalled by fb_ready, and pulses done when a last-flagged
// pixel has been retired.
module pixel_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int DEPTH   = 4,
    parameter int COLOR_W = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [10:0]        in_x,
    input  logic [10:0]        in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_last,
    output logic               fb_we,
    input  logic               fb_ready,
    output logic [18:0]        fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               done,
    output logic [19:0]        pix_count,
    output logic [15:0]        drop_count
);

    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          ENTRY_W = 23 + COLOR_W;
    localparam logic [31:0] H_LIM   = H_RES;
    localparam logic [31:0] V_LIM   = V_RES;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {EMPTY, LOADED} stage_t;

    function automatic logic is_clipped(input logic [10:0] x, input logic [10:0] y);
        return (32'(x) >= H_LIM) || (32'(y) >= V_LIM);
    endfunction

    function automatic logic [18:0] calc_addr(input logic [10:0] x, input logic [10:0] y);
        logic [31:0] lin;
        lin = 32'(y) * H_LIM + 32'(x);
        return lin[18:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- stage p0: input FIFO ----
    logic [ENTRY_W-1:0] mem_p0 [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_p0;
    logic [PTR_W-1:0]   rd_ptr_p0;
    logic [PTR_W:0]     count_p0;

    logic [ENTRY_W-1:0] head_p0;
    logic [10:0]        head_x_p0;
    logic [10:0]        head_y_p0;
    logic [COLOR_W-1:0] head_color_p0;
    logic               head_last_p0;
    logic               full_p0;
    logic               empty_p0;
    logic               push_p0;
    logic               pop_p0;
    logic               clip_p0;
    logic               load_p0;

    // ---- stage p1: output (frame-buffer write) stage ----
    stage_t             state_p1;
    logic               last_p1;
    logic               complete_p1;
    logic [1:0]         done_pend;
    logic [1:0]         done_evt;

    assign head_p0       = mem_p0[rd_ptr_p0];
    assign head_x_p0     = head_p0[10:0];
    assign head_y_p0     = head_p0[21:11];
    assign head_color_p0 = head_p0[22 +: COLOR_W];
    assign head_last_p0  = head_p0[ENTRY_W-1];

    assign full_p0  = (count_p0 == FULL_CNT);
    assign empty_p0 = (count_p0 == '0);
    // No bypass: a full FIFO refuses even when it pops in the same cycle.
    assign in_ready = reset && !full_p0;
    assign push_p0  = in_valid && in_ready;

    assign fb_we       = (state_p1 == LOADED);
    assign complete_p1 = fb_we && fb_ready;
    // The head moves whenever the output stage is free or is draining this cycle.
    assign pop_p0  = !empty_p0 && (!fb_we || fb_ready);
    assign clip_p0 = is_clipped(head_x_p0, head_y_p0);
    assign load_p0 = pop_p0 && !clip_p0;

    // Two retirements can coincide (clipped last head plus completing last write);
    // the surplus is carried so every last pixel gets its own pulse.
    always_comb begin
        done_evt = 2'(pop_p0 && clip_p0 && head_last_p0)
                 + 2'(complete_p1 && last_p1)
                 + done_pend;
    end

    // FIFO storage; data words need no reset, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            mem_p0[wr_ptr_p0] <= {in_last, in_color, in_y, in_x};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (push_p0) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            if (pop_p0)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            if (push_p0 && !pop_p0)      count_p0 <= count_p0 + 1'b1;
            else if (pop_p0 && !push_p0) count_p0 <= count_p0 - 1'b1;
        end
    end

    // Output stage state machine: holds address/data stable while stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_p1 <= EMPTY;
            fb_addr  <= '0;
            fb_data  <= '0;
            last_p1  <= 1'b0;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (load_p0) begin
                        state_p1 <= LOADED;
                        fb_addr  <= calc_addr(head_x_p0, head_y_p0);
                        fb_data  <= head_color_p0;
                        last_p1  <= head_last_p0;
                    end
                end
                LOADED: begin
                    if (load_p0) begin
                        fb_addr  <= calc_addr(head_x_p0, head_y_p0);
                        fb_data  <= head_color_p0;
                        last_p1  <= head_last_p0;
                    end else if (complete_p1) begin
                        state_p1 <= EMPTY;
                    end
                end
                default: state_p1 <= EMPTY;
            endcase
        end
    end

    // Statistics counters and the done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_count  <= '0;
            drop_count <= '0;
            done       <= 1'b0;
            done_pend  <= '0;
        end else begin
            if (complete_p1)         pix_count  <= pix_count + 20'd1;
            if (pop_p0 && clip_p0)   drop_count <= sat_inc16(drop_count);
            done      <= (done_evt != 2'd0);
            done_pend <= (done_evt != 2'd0) ? done_evt - 2'd1 : 2'd0;
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: directed scenarios plus a random stream, checked
// against a queue-based model of the frame-buffer write sequence.
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic [0:0]  in_color;
    logic        in_last;
    logic        fb_we;
    logic        fb_ready;
    logic [18:0] fb_addr;
    logic [0:0]  fb_data;
    logic        done;
    logic [19:0] pix_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    pixel_writer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_last(in_last),
        .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
        .done(done), .pix_count(pix_count), .drop_count(drop_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected write sequence and counts since reset.
    typedef struct { int addr; int data; } wr_t;
    wr_t  exp_q[$];
    int   exp_pix = 0, exp_drop = 0, exp_last = 0, done_seen = 0, wr_total = 0;
    int   last_wr_addr = -1;
    int   win_count = 0, win_first = 0, win_last = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [18:0] prev_addr;
    logic [0:0]  prev_data;
    logic rand_mode = 1'b0;

    function automatic int model_addr(input int x, input int y);
        return y * 640 + x;
    endfunction

    // Compare process: samples on the falling edge what the next rising edge will see.
    always @(negedge clk) begin
        cyc++;
        if (reset !== 1'b1) begin
            exp_q.delete();
            exp_pix = 0; exp_drop = 0; exp_last = 0; done_seen = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_we", fb_we, 1);
                check("hold_addr", fb_addr, prev_addr);
                check("hold_data", fb_data, prev_data);
            end
            if (done === 1'b1) done_seen++;
            if (fb_we && fb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", fb_addr, -1);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", fb_addr, w.addr);
                    check("wr_data", fb_data, w.data);
                end
                last_wr_addr = int'(fb_addr);
                wr_total++;
                if (win_count == 0) win_first = cyc;
                win_last = cyc;
                win_count++;
            end
            if (in_valid && in_ready) begin
                if (in_x >= 640 || in_y >= 480) begin
                    exp_drop++;
                end else begin
                    wr_t w;
                    w.addr = model_addr(int'(in_x), int'(in_y));
                    w.data = int'(in_color);
                    exp_q.push_back(w);
                    exp_pix++;
                end
                if (in_last) exp_last++;
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
        end
    end

    // Random backpressure while the random stream runs.
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            fb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one pixel (call just after a rising edge); returns just after the accepting edge.
    task automatic push(input int x, input int y, input int c, input int l);
        int t;
        in_x = 11'(x); in_y = 11'(y); in_color = 1'(c); in_last = l[0];
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        fb_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || fb_we) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) check({tag, "_drain_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_pix_model"}, pix_count, exp_pix);
        check({tag, "_drop_model"}, drop_count, exp_drop);
        check({tag, "_done_model"}, done_seen, exp_last);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic single_pixel(input string tag);
        fb_ready = 1'b1;
        push(10, 2, 1, 1);
        check({tag, "_we_k"}, fb_we, 0);
        @(posedge clk); #1;
        check({tag, "_we"}, fb_we, 1);
        check({tag, "_addr"}, fb_addr, 1290);
        check({tag, "_data"}, fb_data, 1);
        check({tag, "_done_early"}, done, 0);
        @(posedge clk); #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_pix"}, pix_count, 1);
        check({tag, "_we_drop"}, fb_we, 0);
        @(posedge clk); #1;
        check({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        int snap;
        reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
        in_color = '0; in_last = 1'b0; fb_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        check("rst_done", done, 0);
        check("rst_pix", pix_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("rel_ready", in_ready, 1);
        @(posedge clk); #1;

        // Scenario 1: single pixel latency and address
        single_pixel("s1");

        // Scenario 2: clipping
        push(2047, 5, 1, 0);
        push(639, 479, 1, 1);
        drain("s2");
        check("s2_drop", drop_count, 1);
        check("s2_pix", pix_count, 2);
        check("s2_addr", last_wr_addr, 307199);
        check("s2_done_total", done_seen, 2);

        // Scenario 3: backpressure
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(100 + i, 10, i % 2, 0);
        check("s3_full", in_ready, 0);
        check("s3_we", fb_we, 1);
        check("s3_addr", fb_addr, 6500);
        in_x = 11'd105; in_y = 11'd10; in_color = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("s3_still_full", in_ready, 0);
            check("s3_addr_stable", fb_addr, 6500);
        end
        fb_ready = 1'b1;
        push(105, 10, 1, 1);
        drain("s3");
        check("s3_pix", pix_count, 8);
        check("s3_last_addr", last_wr_addr, 6505);

        // Scenario 4: continuous stream
        win_count = 0;
        for (int i = 0; i < 100; i++) push(i * 3, i, i % 2, (i == 99) ? 1 : 0);
        drain("s4");
        check("s4_writes", win_count, 100);
        check("s4_no_bubbles", win_last - win_first, 99);
        check("s4_pix", pix_count, 108);

        // Scenario 5: reset mid-stream
        fb_ready = 1'b0;
        push(1, 1, 1, 1);
        push(2, 1, 1, 1);
        push(3, 1, 1, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("s5_ready_in_rst", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("s5_we", fb_we, 0);
        check("s5_pix", pix_count, 0);
        check("s5_drop", drop_count, 0);
        check("s5_done", done, 0);
        check("s5_ready", in_ready, 1);
        fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("s5_no_done", done_seen, 0);
        check("s5_no_write", pix_count, 0);
        single_pixel("s5b");
        drain("s5");

        // Scenario 6: simultaneous push/pop at occupancy 2
        fb_ready = 1'b0;
        push(50, 50, 1, 0);
        push(51, 50, 0, 0);
        push(52, 50, 1, 0);
        fb_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(60 + i, 60, i % 2, 0);
        snap = wr_total;
        drain("s6");
        check("s6_remaining", wr_total - snap, 3);
        check("s6_pix", pix_count, 24);

        // Random stream with random stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            push($urandom_range(0, 719), $urandom_range(0, 539),
                 $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 1 : 0);
        end
        rand_mode = 1'b0;
        @(posedge clk); #2;
        drain("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
